ps2_key_ctrl: RTL and testbench
===============================

Name: ps2_key_ctrl

Overview:
- Sequencing controller between the PS/2 byte receiver (`ps2_keyboard`) and the display/ASCII path.
- Parses the raw scancode byte stream:
  - make codes
  - F0 break prefix
  - E0 extended prefix
  - E1 Pause sequence
- Tracks the currently held key, counts distinct key presses, suppresses typematic repeats, and buffers key events in a small FIFO for a downstream consumer with a valid/ready handshake.

Parameters:
- FIFO_DEPTH, 8, event FIFO entries; power of two, ≥2.
- CNT_W, 8, press counter width.

Ports:
- clk  in  1  system clock
- resetn  in  1  synchronous reset, active-low; sampled on rising clk
- rx_valid  in  1  one-cycle strobe: rx_data holds a new received byte
- rx_data  in  8  received scancode byte
- ev_ready  in  1  consumer accepts head event this cycle
- ev_valid  out  1  FIFO non-empty
- ev_code  out  8  head event scancode (F0/E0 stripped)
- ev_ext  out  1  head event was E0-prefixed
- ev_break  out  1  head event is a release (1) or press (0)
- held_valid  out  1  a key is currently held
- held_code  out  8  scancode of held key
- held_ext  out  1  held key is extended
- press_cnt  out  CNT_W  number of accepted presses, wraps
- ev_ovf  out  1  sticky: an event was dropped because the FIFO was full
- seq_err  out  1  one-cycle pulse on an illegal prefix sequence

Behaviour:
- Reset (resetn=0 at a clk edge) applies on that edge, including mid-sequence:
  - parser goes to IDLE and the FIFO is emptied
  - all outputs go to 0: ev_valid, ev_code, ev_ext, ev_break, held_*, press_cnt, ev_ovf, seq_err
- Bytes are only consumed when rx_valid=1; otherwise the parser holds its state.
- Parser states and transitions on rx_valid:
  - IDLE:
    - E0 -> EXT
    - F0 -> BRK
    - E1 -> SKIP, with skip counter = 7
    - other byte -> emit make(byte, ext=0), stay IDLE
  - EXT:
    - F0 -> EXT_BRK
    - E0 -> seq_err, stay EXT
    - E1 -> seq_err, go IDLE
    - other byte -> emit make(byte, ext=1), go IDLE
  - BRK:
    - F0, E0 or E1 -> seq_err, go IDLE
    - other byte -> emit break(byte, ext=0), go IDLE
  - EXT_BRK:
    - F0, E0 or E1 -> seq_err, go IDLE
    - other byte -> emit break(byte, ext=1), go IDLE
  - SKIP: each byte decrements the skip counter; when the counter reaches 0 after a decrement, go IDLE. No events, no count, no seq_err.
- Make handling:
  - If held_valid=1 and {held_ext, held_code} == {ext, code}, the make is a typematic repeat. It is dropped: no FIFO push, no count change.
  - Otherwise:
    - push {code, ext, break=0}
    - load held_* with the new key and set held_valid=1; a newly pressed key replaces the previous held key
    - press_cnt += 1, wrapping from all-ones to 0
- Break handling:
  - Always push {code, ext, break=1}.
  - If it matches the held key, clear held_valid; held_code and held_ext keep their last value.
  - A break of a non-held key leaves held_* unchanged.
- Latency: a byte with rx_valid at edge N has its effects visible after edge N:
  - held_*, press_cnt and seq_err update
  - a pushed event makes ev_valid=1 from cycle N+1 when the FIFO was empty
- FIFO:
  - ev_* always show the head entry.
  - A pop occurs when ev_valid & ev_ready.
  - A push when the FIFO is full is accepted only if a pop happens in the same cycle; otherwise the event is dropped and ev_ovf is set. ev_ovf clears only on reset.
  - Push and pop in the same cycle on a non-empty FIFO leave the occupancy unchanged.
  - ev_ready while empty is ignored.
  - Pointers wrap modulo FIFO_DEPTH. Occupancy is tracked with a (log2 FIFO_DEPTH + 1)-bit count.
- Dropped events still update held_* and press_cnt.
- seq_err is high for exactly one cycle per illegal byte.

Test Plan:
- Reset, then rx bytes 1C, F0, 1C with ev_ready=1 -> two events:
  - {1C, ext0, brk0} then {1C, ext0, brk1}
  - press_cnt=1, held_valid=0 at end, held_code=1C
- Bytes 1C, 1C, 1C, F0, 1C -> only 2 events, press_cnt=1 (repeats suppressed).
- Bytes E0, 75, E0, F0, 75 -> events {75, ext1, brk0} and {75, ext1, brk1}; held_ext=1 while held.
- Pause sequence E1 14 77 E1 F0 14 F0 77, then 1C -> only {1C, brk0} is emitted; no seq_err.
- ev_ready=0, push 9 distinct makes with FIFO_DEPTH=8 -> 8 events are stored, ev_ovf=1, press_cnt=9. Draining pops the first 8 codes in order. The 9th code is absent from the FIFO but is held_code.
- Bytes F0, F0 -> seq_err pulses for exactly one cycle and the parser returns to IDLE. Then resetn=0 after a lone E0 -> all outputs are 0. A following 1C yields ext=0.

Source files
------------

// File: rtl/ps2_key_ctrl_if.sv
// ps2_key_ctrl_if -- key event stream from the scancode controller to its consumer.
//   ev_valid  : head event present (FIFO non-empty)
//   ev_ready  : consumer takes the head event this cycle
//   ev_code   : head event scancode, prefixes stripped
//   ev_ext    : head event was E0-prefixed
//   ev_break  : head event is a release (1) or a press (0)
// master = event producer (ps2_key_ctrl), slave = consumer.
interface ps2_key_ctrl_if;
  logic       ev_valid;
  logic       ev_ready;
  logic [7:0] ev_code;
  logic       ev_ext;
  logic       ev_break;

  modport master (output ev_valid, ev_code, ev_ext, ev_break, input ev_ready);
  modport slave  (input ev_valid, ev_code, ev_ext, ev_break, output ev_ready);
endinterface

// File: rtl/ps2_key_ctrl.sv
// ps2_key_ctrl -- parses the PS/2 scancode byte stream (make, F0 break, E0
// extended, E1 Pause), tracks the held key, counts distinct presses, drops
// typematic repeats and queues key events for a valid/ready consumer.
// Ports:
//   clk, resetn         : clock, synchronous active-low reset
//   rx_valid, rx_data   : one-cycle strobe + received byte
//   ev (master)         : event FIFO head and handshake
//   held_valid/code/ext : currently held key
//   press_cnt           : accepted presses, wraps
//   ev_ovf              : sticky, an event was dropped on a full FIFO
//   seq_err             : one-cycle pulse per illegal prefix byte
module ps2_key_ctrl #(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  ps2_key_ctrl_if.master    ev,
  output logic              held_valid,
  output logic [7:0]        held_code,
  output logic              held_ext,
  output logic [CNT_W-1:0]  press_cnt,
  output logic              ev_ovf,
  output logic              seq_err
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {ST_IDLE, ST_EXT, ST_BRK, ST_EXT_BRK, ST_SKIP} state_e;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
  } event_t;

  state_e           state_q, state_d;
  logic [2:0]       skip_q, skip_d;
  logic             held_valid_q, held_valid_d;
  logic [7:0]       held_code_q, held_code_d;
  logic             held_ext_q, held_ext_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             seq_err_q, seq_err_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  event_t           mem_q [FIFO_DEPTH];

  logic             is_make, is_break, key_ext, key_match;
  logic             push, pop, full, push_ok;
  event_t           push_ev, head;

  // Byte parser: decides what each received byte means.
  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    skip_d    = skip_q;
    seq_err_d = 1'b0;
    is_make   = 1'b0;
    is_break  = 1'b0;
    key_ext   = 1'b0;
    if (rx_valid) begin
      case (state_q)
        ST_IDLE: begin
          case (rx_data)
            8'hE0:   state_d = ST_EXT;
            8'hF0:   state_d = ST_BRK;
            8'hE1: begin
              state_d = ST_SKIP;
              skip_d  = 3'd7;          // rest of the 8-byte Pause sequence
            end
            default: is_make = 1'b1;
          endcase
        end
        ST_EXT: begin
          case (rx_data)
            8'hF0:   state_d = ST_EXT_BRK;
            8'hE0:   seq_err_d = 1'b1; // stay in EXT
            8'hE1: begin
              seq_err_d = 1'b1;
              state_d   = ST_IDLE;
            end
            default: begin
              is_make = 1'b1;
              key_ext = 1'b1;
              state_d = ST_IDLE;
            end
          endcase
        end
        ST_BRK, ST_EXT_BRK: begin
          state_d = ST_IDLE;
          if (rx_data == 8'hF0 || rx_data == 8'hE0 || rx_data == 8'hE1) begin
            seq_err_d = 1'b1;
          end else begin
            is_break = 1'b1;
            key_ext  = (state_q == ST_EXT_BRK);
          end
        end
        ST_SKIP: begin
          skip_d = skip_q - 3'd1;
          if (skip_q == 3'd1) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Held-key tracking, press counter and FIFO bookkeeping.
  always_comb begin
    held_valid_d = held_valid_q;
    held_code_d  = held_code_q;
    held_ext_d   = held_ext_q;
    cnt_d        = cnt_q;

    key_match = held_valid_q && (held_ext_q == key_ext) && (held_code_q == rx_data);
    // A make of the already-held key is a typematic repeat and is discarded.
    push    = is_break || (is_make && !key_match);
    push_ev = '{code: rx_data, ext: key_ext, brk: is_break};

    if (is_make && !key_match) begin
      held_valid_d = 1'b1;
      held_code_d  = rx_data;
      held_ext_d   = key_ext;
      cnt_d        = cnt_q + CNT_W'(1);
    end
    if (is_break && key_match) held_valid_d = 1'b0;

    pop     = (count_q != '0) && ev.ev_ready;
    full    = (count_q == (AW+1)'(FIFO_DEPTH));
    // A full FIFO still takes a push when the head leaves in the same cycle.
    push_ok = push && (!full || pop);
    ovf_d   = ovf_q || (push && !push_ok);

    wr_ptr_d = wr_ptr_q + AW'(push_ok);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + (AW+1)'(push_ok) - (AW+1)'(pop);
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      skip_q       <= '0;
      held_valid_q <= 1'b0;
      held_code_q  <= '0;
      held_ext_q   <= 1'b0;
      cnt_q        <= '0;
      ovf_q        <= 1'b0;
      seq_err_q    <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      skip_q       <= skip_d;
      held_valid_q <= held_valid_d;
      held_code_q  <= held_code_d;
      held_ext_q   <= held_ext_d;
      cnt_q        <= cnt_d;
      ovf_q        <= ovf_d;
      seq_err_q    <= seq_err_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
    end
  end

  // NOTE: the storage array is not reset; the zero count makes stale entries
  // unreachable and the head outputs are forced to 0 while empty.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_ev;
  end

  assign head        = mem_q[rd_ptr_q];
  assign ev.ev_valid = (count_q != '0);
  assign ev.ev_code  = ev.ev_valid ? head.code : 8'h00;
  assign ev.ev_ext   = ev.ev_valid & head.ext;
  assign ev.ev_break = ev.ev_valid & head.brk;

  assign held_valid = held_valid_q;
  assign held_code  = held_code_q;
  assign held_ext   = held_ext_q;
  assign press_cnt  = cnt_q;
  assign ev_ovf     = ovf_q;
  assign seq_err    = seq_err_q;

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// tb_ps2_key_ctrl -- directed scenarios followed by random byte traffic, all
// checked every cycle against a prefix-flag / event-queue reference model.
module tb_ps2_key_ctrl;
  localparam int DEPTH = 8;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
  } ev_t;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       held_valid, held_ext, ev_ovf, seq_err;
  logic [7:0] held_code, press_cnt;

  ps2_key_ctrl_if ev_if ();

  ps2_key_ctrl #(.FIFO_DEPTH(DEPTH), .CNT_W(8)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .ev         (ev_if.master),
    .held_valid (held_valid),
    .held_code  (held_code),
    .held_ext   (held_ext),
    .press_cnt  (press_cnt),
    .ev_ovf     (ev_ovf),
    .seq_err    (seq_err)
  );

  initial forever #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  // Reference model: pending-prefix flags, remaining Pause bytes, expected FIFO.
  bit         m_e0, m_f0;
  int         m_skip;
  bit         m_hv, m_he, m_ovf, m_serr;
  logic [7:0] m_hc, m_cnt;
  ev_t        mq[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_e0 = 0; m_f0 = 0; m_skip = 0;
    m_hv = 0; m_he = 0; m_hc = 8'h00; m_cnt = 8'h00;
    m_ovf = 0; m_serr = 0;
    mq.delete();
  endtask

  task automatic model_push(input ev_t e);
    if (mq.size() < DEPTH) mq.push_back(e);
    else m_ovf = 1;
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (m_skip > 0) begin
      m_skip--;
    end else if (b == 8'hE1) begin
      if (m_e0 || m_f0) m_serr = 1;
      else m_skip = 7;
      m_e0 = 0; m_f0 = 0;
    end else if (b == 8'hF0) begin
      if (m_f0) begin m_serr = 1; m_e0 = 0; m_f0 = 0; end
      else m_f0 = 1;
    end else if (b == 8'hE0) begin
      if (m_f0) begin m_serr = 1; m_e0 = 0; m_f0 = 0; end
      else if (m_e0) m_serr = 1;
      else m_e0 = 1;
    end else begin
      if (m_f0) begin
        model_push('{code: b, ext: m_e0, brk: 1'b1});
        if (m_hv && m_hc == b && m_he == m_e0) m_hv = 0;
      end else if (!(m_hv && m_hc == b && m_he == m_e0)) begin
        model_push('{code: b, ext: m_e0, brk: 1'b0});
        m_hv = 1; m_hc = b; m_he = m_e0;
        m_cnt = m_cnt + 8'd1;
      end
      m_e0 = 0; m_f0 = 0;
    end
  endtask

  task automatic check_outputs();
    check("ev_valid", ev_if.ev_valid, mq.size() > 0);
    if (mq.size() > 0) begin
      check("ev_code",  ev_if.ev_code,  mq[0].code);
      check("ev_ext",   ev_if.ev_ext,   mq[0].ext);
      check("ev_break", ev_if.ev_break, mq[0].brk);
    end
    check("held_valid", held_valid, m_hv);
    check("held_code",  held_code,  m_hc);
    check("held_ext",   held_ext,   m_he);
    check("press_cnt",  press_cnt,  m_cnt);
    check("ev_ovf",     ev_ovf,     m_ovf);
    check("seq_err",    seq_err,    m_serr);
  endtask

  // One clock: drive at the falling edge, predict, check after the rising edge.
  task automatic cycle(input logic v, input logic [7:0] d, input logic rdy);
    rx_valid       = v;
    rx_data        = d;
    ev_if.ev_ready = rdy;
    m_serr = 0;
    if (rdy && mq.size() > 0) void'(mq.pop_front());
    if (v) model_byte(d);
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b1);
  endtask

  task automatic do_reset(input logic v, input logic [7:0] d);
    resetn         = 1'b0;
    rx_valid       = v;
    rx_data        = d;
    ev_if.ev_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resetn   = 1'b1;
    rx_valid = 1'b0;
    model_clear();
    check_outputs();
    check("rst_ev_code",  ev_if.ev_code,  8'h00);
    check("rst_ev_ext",   ev_if.ev_ext,   1'b0);
    check("rst_ev_break", ev_if.ev_break, 1'b0);
  endtask

  logic [7:0] pool [10] = '{8'h1C, 8'h1C, 8'h1D, 8'h75, 8'h14,
                            8'hF0, 8'hF0, 8'hE0, 8'hE0, 8'hE1};

  initial begin
    ev_if.ev_ready = 1'b0;
    model_clear();
    @(negedge clk);

    // Press and release with the consumer always ready.
    do_reset(1'b0, 8'h00);
    cycle(1'b1, 8'h1C, 1'b1);
    cycle(1'b1, 8'hF0, 1'b1);
    cycle(1'b1, 8'h1C, 1'b1);
    drain(2);
    check("t1_press_cnt",  press_cnt,  8'd1);
    check("t1_held_valid", held_valid, 1'b0);
    check("t1_held_code",  held_code,  8'h1C);

    // Typematic repeats are suppressed.
    do_reset(1'b0, 8'h00);
    cycle(1'b1, 8'h1C, 1'b0);
    cycle(1'b1, 8'h1C, 1'b0);
    cycle(1'b1, 8'h1C, 1'b0);
    cycle(1'b1, 8'hF0, 1'b0);
    cycle(1'b1, 8'h1C, 1'b0);
    check("t2_queued",    ev_if.ev_valid, 1'b1);
    check("t2_press_cnt", press_cnt,      8'd1);
    drain(3);

    // Extended key press / release.
    do_reset(1'b0, 8'h00);
    cycle(1'b1, 8'hE0, 1'b0);
    cycle(1'b1, 8'h75, 1'b0);
    check("t3_held_ext", held_ext, 1'b1);
    cycle(1'b1, 8'hE0, 1'b0);
    cycle(1'b1, 8'hF0, 1'b0);
    cycle(1'b1, 8'h75, 1'b0);
    drain(3);

    // Pause sequence is swallowed whole, then a normal key.
    do_reset(1'b0, 8'h00);
    cycle(1'b1, 8'hE1, 1'b0);
    cycle(1'b1, 8'h14, 1'b0);
    cycle(1'b1, 8'h77, 1'b0);
    cycle(1'b1, 8'hE1, 1'b0);
    cycle(1'b1, 8'hF0, 1'b0);
    cycle(1'b1, 8'h14, 1'b0);
    cycle(1'b1, 8'hF0, 1'b0);
    cycle(1'b1, 8'h77, 1'b0);
    check("t4_nothing_queued", ev_if.ev_valid, 1'b0);
    cycle(1'b1, 8'h1C, 1'b0);
    check("t4_press_cnt", press_cnt, 8'd1);
    drain(2);

    // Overflow: nine distinct presses into an eight-entry FIFO.
    do_reset(1'b0, 8'h00);
    cycle(1'b1, 8'h15, 1'b0);
    cycle(1'b1, 8'h1D, 1'b0);
    cycle(1'b1, 8'h24, 1'b0);
    cycle(1'b1, 8'h2D, 1'b0);
    cycle(1'b1, 8'h2C, 1'b0);
    cycle(1'b1, 8'h35, 1'b0);
    cycle(1'b1, 8'h3C, 1'b0);
    cycle(1'b1, 8'h43, 1'b0);
    cycle(1'b1, 8'h44, 1'b0);
    check("t5_ovf",       ev_ovf,    1'b1);
    check("t5_press_cnt", press_cnt, 8'd9);
    check("t5_held_code", held_code, 8'h44);
    drain(9);

    // Illegal prefix, then reset in the middle of an E0 prefix.
    do_reset(1'b0, 8'h00);
    cycle(1'b1, 8'hF0, 1'b0);
    cycle(1'b1, 8'hF0, 1'b0);
    check("t6_seq_err_hi", seq_err, 1'b1);
    cycle(1'b0, 8'h00, 1'b0);
    check("t6_seq_err_lo", seq_err, 1'b0);
    cycle(1'b1, 8'hE0, 1'b0);
    do_reset(1'b1, 8'h75);
    cycle(1'b1, 8'h1C, 1'b0);
    check("t6_ext_after_reset", ev_if.ev_ext, 1'b0);
    drain(2);

    // Random byte traffic with a randomly stalling consumer.
    do_reset(1'b0, 8'h00);
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 3) != 0), pool[$urandom_range(0, 9)],
            ($urandom_range(0, 9) < 3));
    end
    drain(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
